// File: rtl/exp8_escalonador_saidas.sv
// exp8_escalonador_saidas
// Output scheduler for the memory game. Three requesters share the 4-LED bank
// and the buzzer: memory display (req_mem), player feedback (req_jog) and the
// end-of-game animation (req_fim). Each owner has its LED data latched and gets
// a buzzer tone chosen by the LED being driven. A blank guard interval is
// inserted between owners, except when the end animation preempts.
//
// Ports:
//   clock, reset         system clock, asynchronous active-high reset
//   req_mem, dado_mem    memory-display request (level) and LED pattern
//   req_jog, dado_jog    player-feedback request (level) and LED pattern
//   req_fim, ganhou      end-animation request (level), 1 = win, 0 = lose
//   mudo                 buzzer mute (only with ESCALONADOR_MUDO_EN defined)
//   leds, buzzer         board drives
//   grant                00 none, 01 mem, 10 jog, 11 fim
//   ocupado, db_estado   busy flag and current state code
//
// Optional feature macro: ESCALONADOR_MUDO_EN (adds the mudo input).
`timescale 1ns/1ps

module exp8_escalonador_saidas #(
  parameter int unsigned HALF0        = 25000,
  parameter int unsigned HALF1        = 20000,
  parameter int unsigned HALF2        = 16000,
  parameter int unsigned HALF3        = 12500,
  parameter int unsigned STEP_CYCLES  = 12500000,
  parameter int unsigned GUARD_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_mem,
  input  logic [3:0] dado_mem,
  input  logic       req_jog,
  input  logic [3:0] dado_jog,
  input  logic       req_fim,
  input  logic       ganhou,
`ifdef ESCALONADOR_MUDO_EN
  input  logic       mudo,
`endif
  output logic [3:0] leds,
  output logic       buzzer,
  output logic [1:0] grant,
  output logic       ocupado,
  output logic [2:0] db_estado
);

  localparam int unsigned HALF_MAX_A = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int unsigned HALF_MAX_B = (HALF2 > HALF3) ? HALF2 : HALF3;
  localparam int unsigned HALF_MAX   = (HALF_MAX_A > HALF_MAX_B) ? HALF_MAX_A : HALF_MAX_B;
  localparam int unsigned TONE_W     = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int unsigned STEP_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned GUARD_W    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MEM   = 3'd1,
    ST_JOG   = 3'd2,
    ST_FIM   = 3'd3,
    ST_GUARD = 3'd4
  } estado_t;

  estado_t              state_q, state_d;
  logic [3:0]           hold_q, hold_d;    // latched pattern; bit 0 = ganhou in FIM
  logic [1:0]           anim_q, anim_d;    // animation step position
  logic [TONE_W-1:0]    tone_q, tone_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [GUARD_W-1:0]   guard_q, guard_d;
  logic                 buzz_q, buzz_d;    // tone phase, kept running under mute
  logic                 restart_c;         // new owner granted this edge
  logic                 step_adv_c;        // animation advances this edge
  logic [3:0]           pat_d;             // pattern driven after this edge
  logic [1:0]           grant_d;
  logic [TONE_W-1:0]    half_lim_c;
  logic                 mute_c;

`ifdef ESCALONADOR_MUDO_EN
  assign mute_c = mudo;
`else
  assign mute_c = 1'b0;
`endif

  // Index of the lowest lit LED selects the tone.
  function automatic logic [1:0] menor_bit(input logic [3:0] p);
    if (p[0])      return 2'd0;
    else if (p[1]) return 2'd1;
    else if (p[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Next-state, data capture and animation sequencing.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    anim_d     = anim_q;
    step_d     = '0;
    guard_d    = '0;
    restart_c  = 1'b0;
    step_adv_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_fim) begin
          state_d   = ST_FIM;
          hold_d    = {3'b000, ganhou};
          restart_c = 1'b1;
        end else if (req_jog) begin
          state_d   = ST_JOG;
          hold_d    = dado_jog;
          restart_c = 1'b1;
        end else if (req_mem) begin
          state_d   = ST_MEM;
          hold_d    = dado_mem;
          restart_c = 1'b1;
        end
      end
      ST_MEM, ST_JOG: begin
        if (req_fim) begin
          state_d   = ST_FIM;
          hold_d    = {3'b000, ganhou};
          restart_c = 1'b1;
        end else if ((state_q == ST_MEM) ? !req_mem : !req_jog) begin
          state_d = ST_GUARD;
        end
      end
      ST_FIM: begin
        if (!req_fim) begin
          state_d = ST_GUARD;
        end else if (step_q == STEP_W'(STEP_CYCLES - 1)) begin
          anim_d     = anim_q + 2'd1;
          step_adv_c = 1'b1;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (req_fim) begin
          state_d   = ST_FIM;
          hold_d    = {3'b000, ganhou};
          restart_c = 1'b1;
        end else if (guard_q == GUARD_W'(GUARD_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (restart_c) anim_d = 2'd0;
  end

  // LED pattern and grant code that become visible after this edge.
  always_comb begin
    pat_d   = 4'b0000;
    grant_d = 2'b00;
    case (state_d)
      ST_MEM: begin
        pat_d   = hold_d;
        grant_d = 2'b01;
      end
      ST_JOG: begin
        pat_d   = hold_d;
        grant_d = 2'b10;
      end
      ST_FIM: begin
        grant_d = 2'b11;
        if (hold_d[0]) pat_d = 4'b0001 << anim_d;
        else           pat_d = anim_d[0] ? 4'b0000 : 4'b1111;
      end
      default: begin
        pat_d   = 4'b0000;
        grant_d = 2'b00;
      end
    endcase
  end

  // Tone generator: wraps at HALFi-1 and toggles; restarts on grant or step.
  always_comb begin
    case (menor_bit(pat_d))
      2'd0:    half_lim_c = TONE_W'(HALF0 - 1);
      2'd1:    half_lim_c = TONE_W'(HALF1 - 1);
      2'd2:    half_lim_c = TONE_W'(HALF2 - 1);
      default: half_lim_c = TONE_W'(HALF3 - 1);
    endcase
    tone_d = '0;
    buzz_d = 1'b0;
    if (pat_d == 4'b0000) begin
      tone_d = '0;
      buzz_d = 1'b0;
    end else if (restart_c) begin
      tone_d = '0;
      buzz_d = 1'b0;
    end else if (step_adv_c) begin
      tone_d = '0;
      buzz_d = buzz_q;
    end else if (tone_q == half_lim_c) begin
      tone_d = '0;
      buzz_d = ~buzz_q;
    end else begin
      tone_d = tone_q + 1'b1;
      buzz_d = buzz_q;
    end
  end

  // State, counters, latched data and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= 4'b0000;
      anim_q    <= 2'd0;
      tone_q    <= '0;
      step_q    <= '0;
      guard_q   <= '0;
      buzz_q    <= 1'b0;
      leds      <= 4'b0000;
      buzzer    <= 1'b0;
      grant     <= 2'b00;
      ocupado   <= 1'b0;
      db_estado <= 3'd0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      anim_q    <= anim_d;
      tone_q    <= tone_d;
      step_q    <= step_d;
      guard_q   <= guard_d;
      buzz_q    <= buzz_d;
      leds      <= pat_d;
      buzzer    <= buzz_d & ~mute_c;
      grant     <= grant_d;
      ocupado   <= (state_d != ST_IDLE);
      db_estado <= state_d;
    end
  end

endmodule

// File: tb/tb_exp8_escalonador_saidas.sv
// Directed bench for exp8_escalonador_saidas with short tone/step/guard periods.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps

module tb_exp8_escalonador_saidas;

  logic       clock;
  logic       reset;
  logic       req_mem;
  logic [3:0] dado_mem;
  logic       req_jog;
  logic [3:0] dado_jog;
  logic       req_fim;
  logic       ganhou;
  logic       mudo;
  logic [3:0] leds;
  logic       buzzer;
  logic [1:0] grant;
  logic       ocupado;
  logic [2:0] db_estado;

  int n_checks = 0;
  int n_pass   = 0;

  exp8_escalonador_saidas #(
    .HALF0(2), .HALF1(3), .HALF2(4), .HALF3(5),
    .STEP_CYCLES(4), .GUARD_CYCLES(3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_mem  (req_mem),
    .dado_mem (dado_mem),
    .req_jog  (req_jog),
    .dado_jog (dado_jog),
    .req_fim  (req_fim),
    .ganhou   (ganhou),
`ifdef ESCALONADOR_MUDO_EN
    .mudo     (mudo),
`endif
    .leds     (leds),
    .buzzer   (buzzer),
    .grant    (grant),
    .ocupado  (ocupado),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; req_mem = 1'b0; dado_mem = 4'b0000; req_jog = 1'b0;
    dado_jog = 4'b0000; req_fim = 1'b0; ganhou = 1'b0; mudo = 1'b0;
    repeat (2) cyc();
    check("rst_leds",    8'(leds),      8'h00);
    check("rst_buzzer",  8'(buzzer),    8'h00);
    check("rst_grant",   8'(grant),     8'h00);
    check("rst_ocupado", 8'(ocupado),   8'h00);
    check("rst_estado",  8'(db_estado), 8'h00);
    reset = 1'b0;
    cyc();
    check("idle_estado", 8'(db_estado), 8'h00);

    // Basic memory grant, tone half-period 4
    req_mem = 1'b1; dado_mem = 4'b0100;
    cyc();
    check("mem_grant",   8'(grant),     8'h01);
    check("mem_leds",    8'(leds),      8'h04);
    check("mem_estado",  8'(db_estado), 8'h01);
    check("mem_ocupado", 8'(ocupado),   8'h01);
    check("mem_buz0",    8'(buzzer),    8'h00);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check("mem_buz", 8'(buzzer), 8'((k / 4) % 2));
    end
    dado_mem = 4'b0001;
    cyc();
    check("mem_hold_leds", 8'(leds),   8'h04);
    check("mem_hold_buz",  8'(buzzer), 8'h01);

    // Asynchronous reset in the middle of a grant
    req_mem = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("arst_leds",   8'(leds),      8'h00);
    check("arst_buzzer", 8'(buzzer),    8'h00);
    check("arst_grant",  8'(grant),     8'h00);
    check("arst_estado", 8'(db_estado), 8'h00);
    #1 reset = 1'b0;
    cyc();
    check("arst_idle", 8'(db_estado), 8'h00);

    // mem and jog together: jog wins, tone half-period 3
    req_mem = 1'b1; req_jog = 1'b1; dado_mem = 4'b0001; dado_jog = 4'b0010;
    cyc();
    check("arb_grant",  8'(grant),     8'h02);
    check("arb_leds",   8'(leds),      8'h02);
    check("arb_estado", 8'(db_estado), 8'h02);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check("jog_buz", 8'(buzzer), 8'((k / 3) % 2));
    end
    req_jog = 1'b0;
    for (int g = 0; g < 3; g++) begin
      cyc();
      check("grd_estado", 8'(db_estado), 8'h04);
      check("grd_leds",   8'(leds),      8'h00);
      check("grd_buzzer", 8'(buzzer),    8'h00);
      check("grd_grant",  8'(grant),     8'h00);
    end
    cyc();
    check("grd_end_idle", 8'(db_estado), 8'h00);
    cyc();
    check("after_grd_grant", 8'(grant), 8'h01);
    check("after_grd_leds",  8'(leds),  8'h01);

    // End animation (win) preempts mem without guard
    req_fim = 1'b1; ganhou = 1'b1;
    cyc();
    check("win_grant", 8'(grant), 8'h03);
    check("win_leds0", 8'(leds),  8'h01);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      check("win_leds", 8'(leds), 8'(1 << ((k / 4) % 4)));
    end

    // Leave FIM to GUARD, then fim (lose) preempts the guard
    req_fim = 1'b0; req_mem = 1'b0;
    cyc();
    check("fim_exit_grd", 8'(db_estado), 8'h04);
    req_fim = 1'b1; ganhou = 1'b0;
    cyc();
    check("lose_estado", 8'(db_estado), 8'h03);
    check("lose_leds0",  8'(leds),      8'h0f);
    check("lose_buz0",   8'(buzzer),    8'h00);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      check("lose_leds", 8'(leds), (((k / 4) % 2) == 0) ? 8'h0f : 8'h00);
      check("lose_buz", 8'(buzzer),
            ((((k / 4) % 2) == 0) && ((k % 4) >= 2)) ? 8'h01 : 8'h00);
    end
    req_fim = 1'b0;
    repeat (3) cyc();
    check("lose_grd", 8'(db_estado), 8'h04);
    cyc();
    check("lose_idle", 8'(db_estado), 8'h00);

    // Zero pattern: granted, but dark and silent
    req_jog = 1'b1; dado_jog = 4'b0000;
    cyc();
    check("zero_grant", 8'(grant), 8'h02);
    check("zero_leds",  8'(leds),  8'h00);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      check("zero_buz", 8'(buzzer), 8'h00);
    end
    req_jog = 1'b0;
    repeat (4) cyc();
    check("zero_idle", 8'(db_estado), 8'h00);

    // Request drops on the edge that grants it
    req_mem = 1'b1; dado_mem = 4'b1000;
    cyc();
    req_mem = 1'b0;
    check("blip_estado", 8'(db_estado), 8'h01);
    check("blip_leds",   8'(leds),      8'h08);
    cyc();
    check("blip_grd", 8'(db_estado), 8'h04);
    repeat (3) cyc();
    check("blip_idle", 8'(db_estado), 8'h00);

`ifdef ESCALONADOR_MUDO_EN
    // Muted tone keeps its phase, half-period 5
    req_jog = 1'b1; dado_jog = 4'b1000; mudo = 1'b1;
    cyc();
    check("mute_leds", 8'(leds), 8'h08);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      check("mute_buz", 8'(buzzer), 8'h00);
    end
    mudo = 1'b0;
    for (int k = 8; k <= 10; k++) begin
      cyc();
      check("unmute_buz", 8'(buzzer), 8'((k / 5) % 2));
    end
    req_jog = 1'b0;
    repeat (4) cyc();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exp8_escalonador_saidas.md
Name: exp8_escalonador_saidas

Overview:
- Arbitrates the shared 4-LED bank and buzzer of the memory game between three requesters:
  - memory display (req_mem)
  - player feedback (req_jog)
  - end-of-game animation (req_fim)
- Sits between the game control unit's LED/tone request strobes and the board pins.
- Per owner: latches the data, generates the LED-specific buzzer tone, and inserts a blank guard interval between owners.

Parameters:
- HALF0, 25000, buzzer half-period in clocks for LED index 0
- HALF1, 20000, buzzer half-period for LED index 1
- HALF2, 16000, buzzer half-period for LED index 2
- HALF3, 12500, buzzer half-period for LED index 3
- STEP_CYCLES, 12500000, clocks per end-animation step
- GUARD_CYCLES, 500000, blank clocks between owners (≥1)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- req_mem  in  1  memory-display request (level)
- dado_mem  in  4  LED pattern for memory display
- req_jog  in  1  player-feedback request (level)
- dado_jog  in  4  LED pattern of player move
- req_fim  in  1  end-of-game animation request (level)
- ganhou  in  1  1=win animation, 0=lose animation
- leds  out  4  LED drive
- buzzer  out  1  square-wave buzzer drive
- grant  out  2  00 none, 01 mem, 10 jog, 11 fim
- ocupado  out  1  1 when state ≠ IDLE
- db_estado  out  3  current state code

Behaviour:
- Reset is asynchronous, active-high; clock is clock.
- All state, counters and latched data are registered.
- Reset values: state IDLE, leds 0000, buzzer 0, grant 00, ocupado 0, all counters 0.
- State codes:
  - IDLE=0: outputs off.
  - MEM=1: leds=latched dado, tone on.
  - JOG=2: leds=latched dado, tone on.
  - FIM=3: animation.
  - GUARD=4: outputs off, guard counter runs.
- IDLE transitions:
  - Priority is fim > jog > mem.
  - On the edge that sees a request, the controller enters the state, loads data (dado_x or ganhou) into the hold register, and clears the tone and step counters.
  - Grant, leds and buzzer phase are valid after that same edge (1-cycle latency).
- Hold and release:
  - MEM and JOG hold until their own request drops, then go to GUARD.
  - Input data changes during a grant are ignored.
- Preemption:
  - req_fim=1 in MEM, JOG or GUARD goes to FIM on the next edge with no guard interval.
  - jog does not preempt mem; mem does not preempt jog.
- FIM exits to GUARD when req_fim drops.
- GUARD transitions:
  - Counts GUARD_CYCLES clocks, then goes to IDLE.
  - Requests pending at guard end are arbitrated from IDLE on the following edge.
- Tone select:
  - Index is the lowest set bit of the driven LED pattern.
  - Pattern 0000 gives buzzer 0 with the counter held at 0.
- Tone counter:
  - Counts 0..HALFi-1.
  - At terminal count it wraps to 0 and toggles buzzer.
  - First toggle occurs HALFi clocks after grant.
  - buzzer is forced 0 in IDLE and GUARD.
- FIM, win (ganhou latched 1):
  - leds rotate 0001→0010→0100→1000→0001, advancing every STEP_CYCLES.
  - Tone follows the current LED.
  - The tone counter is cleared at each step.
- FIM, lose (ganhou latched 0):
  - leds alternate 1111/0000 every STEP_CYCLES, starting at 1111.
  - Tone index 0 plays while leds are lit; buzzer is 0 while dark.
- Step counter wraps 0..STEP_CYCLES-1 and runs only in FIM.
- Simultaneous req_mem and req_jog from IDLE: jog wins.
- A request dropping on the same edge as its grant: grant still taken, GUARD on the next edge.
- Reset mid-operation returns to IDLE immediately, with all outputs 0.

Optional Feature:
- Macro: ESCALONADOR_MUDO_EN.
- Defined:
  - Adds input port mudo (1 bit).
  - mudo=1 forces buzzer to 0 while the tone counter keeps running, so the phase is preserved when unmuted.
  - leds and the state machine are unaffected.
- Undefined: port absent; behaviour as above.

Test Plan:
- Bench parameters: HALF0=2, HALF1=3, HALF2=4, HALF3=5, STEP_CYCLES=4, GUARD_CYCLES=3.
- Reset: pulse reset mid-cycle → leds=0000, buzzer=0, grant=00, db_estado=0 immediately.
- Basic mem grant: req_mem=1, dado_mem=0100 → next edge grant=01, leds=0100; buzzer toggles every 4 clocks. Change dado_mem to 0001 mid-grant → leds stay 0100.
- Arbitration: req_mem=req_jog=1 together, dado_jog=0010 → grant=10, leds=0010, buzzer period 6 clocks. Drop req_jog → GUARD 3 cycles with leds=0000, then grant=01.
- Preemption: in MEM, raise req_fim with ganhou=1 → next edge grant=11, leds=0001, then 0010 after 4 clocks, 0100 after 8, 1000 after 12, 0001 after 16.
- Lose animation: req_fim=1, ganhou=0 → leds 1111 for 4 clocks, 0000 for 4 clocks, repeating; buzzer toggles every 2 clocks only while lit.
- Zero pattern and mute: req_jog with dado_jog=0000 → leds=0000, buzzer stays 0. With ESCALONADOR_MUDO_EN, dado_jog=1000 and mudo=1 → buzzer 0; drop mudo → toggling resumes with no phase reset.
